// File: rtl/instruction_fetch_if.sv
// Fetch-to-memory and fetch-to-execute signal bundle.
// master = fetch unit, slave = memory/execute side.
interface instruction_fetch_if;
  logic [7:0] pc_out;
  logic [7:0] mem_data_in;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode_out;
  logic [7:0] operand1_out;
  logic [7:0] operand2_out;
  logic       instr_illegal;
  logic       jump_en;
  logic [7:0] jump_addr;

  modport master (
    output pc_out,
    input  mem_data_in,
    output instr_valid,
    input  instr_ready,
    output opcode_out,
    output operand1_out,
    output operand2_out,
    output instr_illegal,
    input  jump_en,
    input  jump_addr
  );

  modport slave (
    input  pc_out,
    output mem_data_in,
    input  instr_valid,
    output instr_ready,
    input  opcode_out,
    input  operand1_out,
    input  operand2_out,
    input  instr_illegal,
    output jump_en,
    output jump_addr
  );
endinterface

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: assembles 1..3 byte
// instructions and hands them to execute via valid/ready.
module instruction_fetch (
  input  logic                   clk,
  input  logic                   rst,
  instruction_fetch_if.master    bus
);

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_OP1,
    FETCH_OP2,
    ISSUE
  } state_t;

  state_t     state;
  logic [7:0] pc_q;
  logic [7:0] opcode_q;
  logic [7:0] op1_q;
  logic [7:0] op2_q;
  logic       illegal_q;
  logic       valid_q;
  logic [1:0] len_q;

  logic [1:0] dec_len;
  logic       dec_legal;
  logic [7:0] pc_inc;

  assign pc_inc = pc_q + 8'd1;

  // Length table for the byte on the memory bus; unknown
  // opcodes are treated as single-byte and flagged.
  always_comb begin
    dec_len   = 2'd1;
    dec_legal = 1'b0;
    case (bus.mem_data_in)
      8'h00: begin dec_len = 2'd1; dec_legal = 1'b1; end
      8'h04: begin dec_len = 2'd3; dec_legal = 1'b1; end
      8'h06: begin dec_len = 2'd3; dec_legal = 1'b1; end
      8'h08: begin dec_len = 2'd2; dec_legal = 1'b1; end
      8'h0A: begin dec_len = 2'd2; dec_legal = 1'b1; end
      8'h0C: begin dec_len = 2'd2; dec_legal = 1'b1; end
      8'h0E: begin dec_len = 2'd2; dec_legal = 1'b1; end
      8'h10: begin dec_len = 2'd2; dec_legal = 1'b1; end
      default: begin
        dec_len   = 2'd1;
        dec_legal = 1'b0;
      end
    endcase
  end

  // Fetch FSM; a redirect wins over everything, including
  // a transfer completing on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH_OP;
      pc_q      <= 8'h00;
      opcode_q  <= 8'h00;
      op1_q     <= 8'h00;
      op2_q     <= 8'h00;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
      len_q     <= 2'd1;
    end else if (bus.jump_en) begin
      state   <= FETCH_OP;
      pc_q    <= bus.jump_addr;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        FETCH_OP: begin
          pc_q <= pc_inc;
          if (bus.mem_data_in != 8'h00) begin
            opcode_q  <= bus.mem_data_in;
            op1_q     <= 8'h00;
            op2_q     <= 8'h00;
            illegal_q <= ~dec_legal;
            len_q     <= dec_len;
            if (dec_len == 2'd1) begin
              state   <= ISSUE;
              valid_q <= 1'b1;
            end else begin
              state <= FETCH_OP1;
            end
          end
        end
        FETCH_OP1: begin
          pc_q  <= pc_inc;
          op1_q <= bus.mem_data_in;
          if (len_q == 2'd3) begin
            state <= FETCH_OP2;
          end else begin
            state   <= ISSUE;
            valid_q <= 1'b1;
          end
        end
        FETCH_OP2: begin
          pc_q    <= pc_inc;
          op2_q   <= bus.mem_data_in;
          state   <= ISSUE;
          valid_q <= 1'b1;
        end
        ISSUE: begin
          if (bus.instr_ready) begin
            state   <= FETCH_OP;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.instr_valid   = valid_q;
  assign bus.opcode_out    = opcode_q;
  assign bus.operand1_out  = op1_q;
  assign bus.operand2_out  = op2_q;
  assign bus.instr_illegal = illegal_q;

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have clk, input, 1: single clock, all state updates on rising edge.
REQ-002 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have pc_out, output, 8: program counter, drives program memory addr_in.
REQ-004 SHALL have mem_data_in, input, 8: program memory data_out, combinational from pc_out in the same cycle.
REQ-005 SHALL have instr_valid, output, 1: assembled instruction available.
REQ-006 SHALL have instr_ready, input, 1: execute stage accepts instruction.
REQ-007 SHALL have opcode_out, output, 8: opcode byte.
REQ-008 SHALL have operand1_out, output, 8: first operand byte, 0x00 if unused.
REQ-009 SHALL have operand2_out, output, 8: second operand byte, 0x00 if unused.
REQ-010 SHALL have instr_illegal, output, 1: opcode not in length table; meaningful only with instr_valid.
REQ-011 SHALL have jump_en, input, 1: redirect request from execute stage.
REQ-012 SHALL have jump_addr, input, 8: redirect target.

Function
REQ-013 SHALL use FSM states FETCH_OP, FETCH_OP1, FETCH_OP2, ISSUE.
REQ-014 SHALL use length table: 0x00 NOP=1; 0x04 MOV reg->addr=3; 0x06 MOV imm->reg=3; 0x08 ADD, 0x0A JMP, 0x0C AND, 0x0E CLR, 0x10 LSHIFT=2; any other=1 with illegal flag.
REQ-015 SHALL, in FETCH_OP, register mem_data_in as opcode, increment pc_out, and go to FETCH_OP1 (length 2/3) or ISSUE (length 1, non-NOP).
REQ-016 SHALL consume NOP (0x00) internally: pc_out increments, state stays FETCH_OP, nothing issued.
REQ-017 SHALL, in FETCH_OP1, register operand1, increment pc_out, go to FETCH_OP2 (length 3) or ISSUE (length 2).
REQ-018 SHALL, in FETCH_OP2, register operand2, increment pc_out, go to ISSUE.
REQ-019 SHALL assert instr_valid exactly while in ISSUE; pc_out not incremented in ISSUE.
REQ-020 SHALL hold opcode_out, operand1_out, operand2_out and instr_illegal stable while instr_valid=1 and instr_ready=0.
REQ-021 SHALL complete transfer on a rising edge with instr_valid=1 and instr_ready=1, then enter FETCH_OP; instr_valid deasserts next cycle.
REQ-022 SHALL clear unused operand registers to 0x00 when a new opcode is captured.
REQ-023 SHALL wrap pc_out 0xFF -> 0x00 modulo 256, including mid-instruction operand fetch.
REQ-024 SHALL, on jump_en=1 at a rising edge in any state, load pc_out=jump_addr, go to FETCH_OP, discard partial or pending instruction; jump overrides a simultaneous valid/ready transfer (not counted as accepted).
REQ-025 SHALL fetch one byte per cycle; 3-byte instruction issued 3 edges after its opcode address is on pc_out.

Reset
REQ-026 SHALL, while rst=1, force pc_out=0x00, state FETCH_OP, instr_valid=0, instr_illegal=0, opcode_out/operand1_out/operand2_out=0x00, independent of clk.
REQ-027 SHALL abandon any partial instruction on reset mid-operation; first fetch after release is address 0x00.

Verification
REQ-028 SHALL cover: memory {00,06,50,02,04,02,D0}, ready=1 -> after edge 4 valid with 06/50/02, pc_out=0x04; after edge 8 valid with 04/02/D0, pc_out=0x07.
REQ-029 SHALL cover: ready=0 for 5 cycles during first ISSUE -> fields hold 06/50/02, pc_out stays 0x04, single transfer when ready rises.
REQ-030 SHALL cover: jump_en=1, jump_addr=0x01 while in FETCH_OP1 of instruction at 0x04 -> partial discarded, pc_out=0x01 next cycle, next issued instruction 06/50/02.
REQ-031 SHALL cover: pc_out=0xFE, memory[FE]=06,[FF]=11,[00]=22 -> issued 06/11/22, pc_out=0x01.
REQ-032 SHALL cover: memory[0]=0xFF -> valid after edge 1 with opcode FF, instr_illegal=1, operands 00, pc_out=0x01.
REQ-033 SHALL cover: rst asserted mid FETCH_OP2 between edges -> all outputs reset immediately; after release, fetch restarts at 0x00.
